// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: UART receive control FSM; UART_RX_BRK_DET_EN adds break detection (brk_det)
module uart_rx_fsm #(
  parameter int DATA_W  = 8,
  parameter int PRESC_W = 6,
  parameter int BIT_W   = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               RX_IN,
  input  logic               PAR_EN,
  input  logic [PRESC_W-1:0] Prescale,
  input  logic               strt_glitch,
  input  logic               par_err,
  input  logic               stp_err,
  output logic [PRESC_W-1:0] edge_cnt,
  output logic [BIT_W-1:0]   bit_cnt,
  output logic               dat_samp_en,
  output logic               deser_en,
  output logic               strt_chk_en,
  output logic               par_chk_en,
  output logic               stp_chk_en,
  output logic               data_valid,
  output logic               frm_err
`ifdef UART_RX_BRK_DET_EN
  ,
  output logic               brk_det
`endif
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, state_d;
  logic [PRESC_W-1:0] presc_q;
  logic par_flag, bit_end, last_bit, start_ok;
  assign bit_end  = edge_cnt == presc_q - PRESC_W'(1);
  assign last_bit = bit_cnt == BIT_W'(DATA_W - 1);
`ifdef UART_RX_BRK_DET_EN
  logic brk_zero, brk_wait, brk_hit;
  assign start_ok = state == IDLE && !RX_IN && !brk_wait;
  assign brk_hit  = stp_chk_en && stp_err && brk_zero;
`else
  assign start_ok = state == IDLE && !RX_IN;
`endif
  always_ff @(posedge CLK or negedge RST)
    if (!RST) state <= IDLE;
    else      state <= state_d;
  always_comb begin
    state_d     = state;
    dat_samp_en = state != IDLE;
    strt_chk_en = state == START  && bit_end;
    deser_en    = state == DATA   && bit_end;
    par_chk_en  = state == PARITY && bit_end;
    stp_chk_en  = state == STOP   && bit_end;
    case (state)
      IDLE:    state_d = start_ok ? START : IDLE;
      START:   state_d = !bit_end ? START : strt_glitch ? IDLE : DATA;
      DATA:    state_d = !(bit_end && last_bit) ? DATA : PAR_EN ? PARITY : STOP;
      PARITY:  state_d = bit_end ? STOP : PARITY;
      STOP:    state_d = bit_end ? IDLE : STOP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      presc_q    <= PRESC_W'(8);
      par_flag   <= 1'b0;
      data_valid <= 1'b0;
      frm_err    <= 1'b0;
    end else begin
      edge_cnt   <= (state == IDLE || bit_end) ? '0 : edge_cnt + PRESC_W'(1);
      data_valid <= stp_chk_en && !par_flag && !stp_err;
      if (deser_en) bit_cnt <= last_bit ? '0 : bit_cnt + BIT_W'(1);
      if (par_chk_en) par_flag <= par_err;
      if (stp_chk_en && (par_flag || stp_err)) frm_err <= 1'b1;
      if (start_ok) begin
        presc_q  <= (Prescale < PRESC_W'(4)) ? PRESC_W'(4) : Prescale;
        par_flag <= 1'b0;
        frm_err  <= 1'b0;
      end
    end
`ifdef UART_RX_BRK_DET_EN
  // brk_zero stays set only while every data bit end sees a low line
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      brk_zero <= 1'b0;
      brk_wait <= 1'b0;
      brk_det  <= 1'b0;
    end else begin
      brk_det <= brk_hit;
      if (start_ok) brk_zero <= 1'b1;
      else if (deser_en && RX_IN) brk_zero <= 1'b0;
      if (brk_hit) brk_wait <= 1'b1;
      else if (state == IDLE && RX_IN) brk_wait <= 1'b0;
    end
`endif
endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb_uart_rx_fsm: table-driven frame bench for uart_rx_fsm plus reset-abort sequences
module tb_uart_rx_fsm;
  localparam int PW = 6, BW = 4;
  logic CLK = 1'b0, RST = 1'b0, RX_IN = 1'b1, PAR_EN = 1'b0;
  logic [PW-1:0] Prescale = PW'(8);
  logic strt_glitch = 1'b0, par_err = 1'b0, stp_err = 1'b0;
  logic [PW-1:0] edge_cnt;
  logic [BW-1:0] bit_cnt;
  logic dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid, frm_err;
  int vec_cnt = 0, miss_cnt = 0;
  uart_rx_fsm dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .Prescale(Prescale),
    .strt_glitch(strt_glitch), .par_err(par_err), .stp_err(stp_err),
    .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .dat_samp_en(dat_samp_en), .deser_en(deser_en),
    .strt_chk_en(strt_chk_en), .par_chk_en(par_chk_en), .stp_chk_en(stp_chk_en),
    .data_valid(data_valid), .frm_err(frm_err)
  );
  always #5 CLK = ~CLK;
  typedef struct {
    int presc, mid_presc;
    logic par_en, glitch, perr, serr;
    logic [7:0] data;
    logic b2b, exp_valid, exp_frm;
  } vec_t;
  vec_t tbl[11];
  task automatic chk(input string nm, input int act, input int exp);
    vec_cnt++;
    if (act != exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask
  function automatic int outs();
    return int'({edge_cnt, bit_cnt, dat_samp_en, deser_en, strt_chk_en, par_chk_en,
                 stp_chk_en, data_valid, frm_err});
  endfunction
  // Drive one frame from the negedge before the detecting clock edge; sample n is taken
  // at the negedge after clock edge n, so data_valid is expected at n = P*bits+1.
  task automatic run_frame(input vec_t v);
    int p, nb, len, k, nd, ns, np, nt, bad_ec, bad_bc, bad_pl, bad_se, early_dv;
    logic [10:0] line;
    p  = v.presc < 4 ? 4 : v.presc;
    nb = v.glitch ? 1 : (v.par_en ? 11 : 10);
    len = p * nb + 1;
    line = '1;
    line[0] = 1'b0;
    line[8:1] = v.data;
    if (v.par_en) line[9] = ^v.data;
    {nd, ns, np, nt, bad_ec, bad_bc, bad_pl, bad_se, early_dv} = '0;
    Prescale = PW'(v.presc);
    PAR_EN = v.par_en;
    strt_glitch = v.glitch;
    par_err = v.perr;
    stp_err = v.serr;
    RX_IN = 1'b0;
    for (int n = 1; n <= len; n++) begin
      @(negedge CLK);
      if (n < len) begin
        k = (n - 1) / p;
        RX_IN = line[k];
        if (n == 3 * p) Prescale = PW'(v.mid_presc);
        if (n == p * (nb - 1) + 1) PAR_EN = ~v.par_en;
        if (n == 1) chk("frm_err_cleared_at_start", int'(frm_err), 0);
        if (int'(edge_cnt) != (n - 1) % p) bad_ec++;
        if (int'(bit_cnt) != ((k >= 1 && k <= 8) ? k - 1 : 0)) bad_bc++;
        if (!dat_samp_en) bad_se++;
        if (data_valid) early_dv++;
        if (deser_en) begin
          nd++;
          if (int'(edge_cnt) != p - 1 || int'(bit_cnt) != nd - 1) bad_pl++;
        end
        ns += int'(strt_chk_en);
        np += int'(par_chk_en);
        nt += int'(stp_chk_en);
      end
    end
    chk("data_valid_at_end", int'(data_valid), int'(v.exp_valid));
    chk("frm_err_at_end", int'(frm_err), int'(v.exp_frm));
    chk("idle_at_end", int'({dat_samp_en, edge_cnt, bit_cnt}), 0);
    chk("edge_cnt_sequence_errors", bad_ec, 0);
    chk("bit_cnt_sequence_errors", bad_bc, 0);
    chk("dat_samp_en_low_cycles", bad_se, 0);
    chk("early_data_valid", early_dv, 0);
    chk("deser_en_count", nd, v.glitch ? 0 : 8);
    chk("deser_en_placement_errors", bad_pl, 0);
    chk("strt_chk_en_count", ns, 1);
    chk("par_chk_en_count", np, int'(v.par_en && !v.glitch));
    chk("stp_chk_en_count", nt, int'(!v.glitch));
    PAR_EN = v.par_en;
    RX_IN = 1'b1;
    if (!v.b2b) repeat (3) @(negedge CLK);
  endtask
  initial begin
    int dv;
    tbl[0]  = '{8, 8, 1'b0, 1'b0, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{16, 16, 1'b1, 1'b0, 1'b1, 1'b0, 8'h55, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{16, 16, 1'b1, 1'b0, 1'b0, 1'b0, 8'h12, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{8, 8, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{8, 8, 1'b0, 1'b0, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{32, 8, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA3, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{8, 8, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{2, 2, 1'b1, 1'b0, 1'b0, 1'b0, 8'hF0, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{4, 4, 1'b0, 1'b0, 1'b1, 1'b0, 8'h81, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{5, 5, 1'b1, 1'b0, 1'b0, 1'b1, 8'h7E, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{8, 8, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    repeat (3) @(negedge CLK);
    chk("outputs_in_reset", outs(), 0);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    chk("outputs_after_reset", outs(), 0);
    for (int i = 0; i < 11; i++) run_frame(tbl[i]);
    // abort a frame at data bit 4 with an asynchronous reset
    Prescale = PW'(8);
    PAR_EN = 1'b0;
    {strt_glitch, par_err, stp_err} = '0;
    RX_IN = 1'b0;
    for (int n = 1; n <= 8 * 5 + 4; n++) begin
      @(negedge CLK);
      RX_IN = ((n - 1) / 8 == 0) ? 1'b0 : 1'b1;
    end
    chk("bit_cnt_before_abort", int'(bit_cnt), 4);
    #2 RST = 1'b0;
    #1 chk("outputs_async_reset", outs(), 0);
    @(negedge CLK);
    RST = 1'b1;
    RX_IN = 1'b1;
    dv = 0;
    repeat (100) begin
      @(negedge CLK);
      dv += int'(data_valid);
    end
    chk("no_data_valid_after_abort", dv, 0);
    run_frame('{2, 2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b0});
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end
endmodule
